// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: data/address widths, the reserved
// address, and the FSM state encoding used by the controller and assertions.
package router_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 2;
   localparam logic [ADDR_WIDTH-1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } router_state_e;

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity over header+payload, capture of the packet parity byte,
// and the sticky parity_done / err flags reported back to the FSM.
module router_parity_chk #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  acc_en,
   input  logic [DATA_WIDTH-1:0] acc_data,
   input  logic                  capture_en,
   input  logic [DATA_WIDTH-1:0] capture_data,
   output logic                  parity_done,
   output logic                  err
);
   import router_pkg::*;

   logic [DATA_WIDTH-1:0] int_parity_reg;
   logic [DATA_WIDTH-1:0] pkt_parity_reg;
   logic                  parity_done_reg;
   logic                  err_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         int_parity_reg  <= '0;
         pkt_parity_reg  <= '0;
         parity_done_reg <= 1'b0;
         err_reg         <= 1'b0;
      end else begin
         if (acc_en)
            int_parity_reg <= int_parity_reg ^ acc_data;
         if (capture_en) begin
            pkt_parity_reg  <= capture_data;
            parity_done_reg <= 1'b1;
         end
         // Compare one cycle after capture so err is settled by CHECK_PARITY_ERROR.
         if (parity_done_reg && !err_reg)
            err_reg <= (int_parity_reg != pkt_parity_reg);
      end
   end

   assign parity_done = parity_done_reg;
   assign err         = err_reg;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, full-FIFO hold byte and the
// FIFO write data mux, with parity checking delegated to router_parity_chk.
module router_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  detect_add,
   input  logic                  lfd_state,
   input  logic                  ld_state,
   input  logic                  laf_state,
   input  logic                  full_state,
   input  logic                  rst_int_reg,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  parity_done,
   output logic                  low_pkt_valid,
   output logic                  err
);
   import router_pkg::*;

   logic [DATA_WIDTH-1:0] dout_reg;
   logic [DATA_WIDTH-1:0] header_reg;
   logic [DATA_WIDTH-1:0] hold_byte_reg;
   logic                  low_pkt_valid_reg;
   logic                  acc_en;
   logic [DATA_WIDTH-1:0] acc_data;
   logic                  capture_en;
   logic                  parity_done_int;

   always_ff @(posedge clk) begin
      if (reset) begin
         dout_reg          <= '0;
         header_reg        <= '0;
         hold_byte_reg     <= '0;
         low_pkt_valid_reg <= 1'b0;
      end else begin
         if (detect_add && pkt_valid && (data_in[ADDR_WIDTH-1:0] != ADDR_INVALID))
            header_reg <= data_in;

         if (lfd_state)
            dout_reg <= header_reg;
         else if (ld_state && !fifo_full)
            dout_reg <= data_in;
         else if (laf_state)
            dout_reg <= hold_byte_reg;

         // Byte on the bus in the cycle the FIFO filled; replayed in LOAD_AFTER_FULL.
         if (ld_state && fifo_full)
            hold_byte_reg <= data_in;

         if (rst_int_reg)
            low_pkt_valid_reg <= 1'b0;
         else if (ld_state && !pkt_valid)
            low_pkt_valid_reg <= 1'b1;
      end
   end

   // The parity byte arrives with pkt_valid low, so it is never accumulated.
   assign acc_en     = lfd_state | (ld_state & pkt_valid & ~full_state);
   assign acc_data   = lfd_state ? header_reg : data_in;
   assign capture_en = (ld_state & ~fifo_full & ~pkt_valid)
                     | (laf_state & low_pkt_valid_reg & ~parity_done_int);

   router_parity_chk #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity_chk (
      .clk          (clk),
      .reset        (reset),
      .clear        (detect_add),
      .acc_en       (acc_en),
      .acc_data     (acc_data),
      .capture_en   (capture_en),
      .capture_data (data_in),
      .parity_done  (parity_done_int),
      .err          (err)
   );

   assign dout          = dout_reg;
   assign parity_done   = parity_done_int;
   assign low_pkt_valid = low_pkt_valid_reg;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: FSM strobes are sequenced by hand and every
// output is compared against hand-computed values one step after each edge.
module tb_router_reg;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       fifo_full = 1'b0;
   logic       detect_add = 1'b0;
   logic       lfd_state = 1'b0;
   logic       ld_state = 1'b0;
   logic       laf_state = 1'b0;
   logic       full_state = 1'b0;
   logic       rst_int_reg = 1'b0;
   logic [7:0] dout;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       err;

   int total_count = 0;
   int pass_count  = 0;

   router_reg #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .rst_int_reg   (rst_int_reg),
      .dout          (dout),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .err           (err)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe order: detect_add, lfd, ld, laf, full, rst_int.
   task automatic drive(input logic [5:0] s, input logic pv, input logic [7:0] d, input logic ff);
      {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = s;
      pkt_valid = pv;
      data_in   = d;
      fifo_full = ff;
   endtask

   localparam logic [5:0] S_IDLE = 6'b000000;
   localparam logic [5:0] S_DA   = 6'b100000;
   localparam logic [5:0] S_LFD  = 6'b010000;
   localparam logic [5:0] S_LD   = 6'b001000;
   localparam logic [5:0] S_LAF  = 6'b000100;
   localparam logic [5:0] S_FULL = 6'b000010;
   localparam logic [5:0] S_CHK  = 6'b000001;

   task automatic test_reset();
      reset = 1'b1;
      drive(S_IDLE, 1'b0, 8'h00, 1'b0);
      tick(); tick();
      reset = 1'b0;
      total_count++; if (dout !== 8'h00) $display("FAIL rst_dout got %h exp 00", dout); else pass_count++;
      total_count++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else pass_count++;
      total_count++; if (parity_done !== 1'b0) $display("FAIL rst_pd got %b exp 0", parity_done); else pass_count++;
      total_count++; if (low_pkt_valid !== 1'b0) $display("FAIL rst_low got %b exp 0", low_pkt_valid); else pass_count++;
      // Build up state mid-packet, then reset over it.
      drive(S_DA, 1'b1, 8'hA5, 1'b0);  tick();
      drive(S_LFD, 1'b1, 8'hA5, 1'b0); tick();
      drive(S_LD, 1'b0, 8'hA5, 1'b0);  tick();
      total_count++; if (dout !== 8'hA5) $display("FAIL rst_pre_dout got %h exp a5", dout); else pass_count++;
      total_count++; if (low_pkt_valid !== 1'b1) $display("FAIL rst_pre_low got %b exp 1", low_pkt_valid); else pass_count++;
      total_count++; if (parity_done !== 1'b1) $display("FAIL rst_pre_pd got %b exp 1", parity_done); else pass_count++;
      reset = 1'b1;
      drive(S_LD, 1'b1, 8'h5A, 1'b0);
      tick();
      reset = 1'b0;
      total_count++; if (dout !== 8'h00) $display("FAIL rst_mid_dout got %h exp 00", dout); else pass_count++;
      total_count++; if (parity_done !== 1'b0) $display("FAIL rst_mid_pd got %b exp 0", parity_done); else pass_count++;
      total_count++; if (low_pkt_valid !== 1'b0) $display("FAIL rst_mid_low got %b exp 0", low_pkt_valid); else pass_count++;
      total_count++; if (err !== 1'b0) $display("FAIL rst_mid_err got %b exp 0", err); else pass_count++;
      $display("test_reset done");
   endtask

   // Header 0D, payload 11 22 33; correct parity is 0D.
   task automatic test_packet(input logic [7:0] par, input logic exp_err, input string tag);
      drive(S_DA, 1'b1, 8'h0D, 1'b0);  tick();
      drive(S_LFD, 1'b1, 8'h11, 1'b0); tick();
      total_count++; if (dout !== 8'h0D) $display("FAIL %s_hdr got %h exp 0d", tag, dout); else pass_count++;
      drive(S_LD, 1'b1, 8'h11, 1'b0);  tick();
      total_count++; if (dout !== 8'h11) $display("FAIL %s_d1 got %h exp 11", tag, dout); else pass_count++;
      drive(S_LD, 1'b1, 8'h22, 1'b0);  tick();
      total_count++; if (dout !== 8'h22) $display("FAIL %s_d2 got %h exp 22", tag, dout); else pass_count++;
      drive(S_LD, 1'b1, 8'h33, 1'b0);  tick();
      total_count++; if (dout !== 8'h33) $display("FAIL %s_d3 got %h exp 33", tag, dout); else pass_count++;
      total_count++; if (parity_done !== 1'b0) $display("FAIL %s_pd_early got %b exp 0", tag, parity_done); else pass_count++;
      drive(S_LD, 1'b0, par, 1'b0);    tick();
      total_count++; if (parity_done !== 1'b1) $display("FAIL %s_pd got %b exp 1", tag, parity_done); else pass_count++;
      total_count++; if (low_pkt_valid !== 1'b1) $display("FAIL %s_low got %b exp 1", tag, low_pkt_valid); else pass_count++;
      total_count++; if (err !== 1'b0) $display("FAIL %s_err_early got %b exp 0", tag, err); else pass_count++;
      drive(S_CHK, 1'b0, 8'h00, 1'b0); tick();
      total_count++; if (err !== exp_err) $display("FAIL %s_err got %b exp %b", tag, err, exp_err); else pass_count++;
      total_count++; if (low_pkt_valid !== 1'b0) $display("FAIL %s_low_clr got %b exp 0", tag, low_pkt_valid); else pass_count++;
      drive(S_DA, 1'b0, 8'h00, 1'b0);  tick();
      total_count++; if (err !== 1'b0) $display("FAIL %s_err_clr got %b exp 0", tag, err); else pass_count++;
      total_count++; if (parity_done !== 1'b0) $display("FAIL %s_pd_clr got %b exp 0", tag, parity_done); else pass_count++;
      drive(S_IDLE, 1'b0, 8'h00, 1'b0);
      $display("test_packet %s done", tag);
   endtask

   // Running parity: 0D^11^44^22 = 7A.
   task automatic test_fifo_full_mid();
      drive(S_DA, 1'b1, 8'h0D, 1'b0);   tick();
      drive(S_LFD, 1'b1, 8'h11, 1'b0);  tick();
      drive(S_LD, 1'b1, 8'h11, 1'b0);   tick();
      drive(S_LD, 1'b1, 8'h44, 1'b1);   tick();
      total_count++; if (dout !== 8'h11) $display("FAIL full_hold_dout got %h exp 11", dout); else pass_count++;
      drive(S_FULL, 1'b1, 8'h44, 1'b1); tick();
      total_count++; if (dout !== 8'h11) $display("FAIL full_state_dout got %h exp 11", dout); else pass_count++;
      drive(S_LAF, 1'b1, 8'h55, 1'b0);  tick();
      total_count++; if (dout !== 8'h44) $display("FAIL full_laf_dout got %h exp 44", dout); else pass_count++;
      drive(S_LD, 1'b1, 8'h22, 1'b0);   tick();
      total_count++; if (dout !== 8'h22) $display("FAIL full_resume_dout got %h exp 22", dout); else pass_count++;
      drive(S_LD, 1'b0, 8'h7A, 1'b0);   tick();
      total_count++; if (parity_done !== 1'b1) $display("FAIL full_pd got %b exp 1", parity_done); else pass_count++;
      drive(S_CHK, 1'b0, 8'h00, 1'b0);  tick();
      total_count++; if (err !== 1'b0) $display("FAIL full_err got %b exp 0", err); else pass_count++;
      drive(S_IDLE, 1'b0, 8'h00, 1'b0);
      $display("test_fifo_full_mid done");
   endtask

   // FIFO fills exactly as the parity byte 0D arrives; capture happens in LAF.
   task automatic test_full_at_end();
      drive(S_DA, 1'b1, 8'h0D, 1'b0);   tick();
      drive(S_LFD, 1'b1, 8'h11, 1'b0);  tick();
      drive(S_LD, 1'b1, 8'h11, 1'b0);   tick();
      drive(S_LD, 1'b1, 8'h22, 1'b0);   tick();
      drive(S_LD, 1'b1, 8'h33, 1'b0);   tick();
      drive(S_LD, 1'b0, 8'h0D, 1'b1);   tick();
      total_count++; if (dout !== 8'h33) $display("FAIL end_dout_hold got %h exp 33", dout); else pass_count++;
      total_count++; if (parity_done !== 1'b0) $display("FAIL end_pd_nocap got %b exp 0", parity_done); else pass_count++;
      total_count++; if (low_pkt_valid !== 1'b1) $display("FAIL end_low got %b exp 1", low_pkt_valid); else pass_count++;
      drive(S_FULL, 1'b0, 8'h0D, 1'b1); tick();
      total_count++; if (parity_done !== 1'b0) $display("FAIL end_pd_full got %b exp 0", parity_done); else pass_count++;
      drive(S_LAF, 1'b0, 8'h0D, 1'b0);  tick();
      total_count++; if (dout !== 8'h0D) $display("FAIL end_laf_dout got %h exp 0d", dout); else pass_count++;
      total_count++; if (parity_done !== 1'b1) $display("FAIL end_pd got %b exp 1", parity_done); else pass_count++;
      drive(S_LAF, 1'b0, 8'hFF, 1'b0);  tick();
      drive(S_CHK, 1'b0, 8'h00, 1'b0);  tick();
      total_count++; if (err !== 1'b0) $display("FAIL end_no_recap_err got %b exp 0", err); else pass_count++;
      drive(S_IDLE, 1'b0, 8'h00, 1'b0);
      $display("test_full_at_end done");
   endtask

   task automatic test_invalid_addr();
      drive(S_DA, 1'b1, 8'h0E, 1'b0);  tick();
      drive(S_DA, 1'b1, 8'h07, 1'b0);  tick();
      drive(S_LFD, 1'b1, 8'h00, 1'b0); tick();
      total_count++; if (dout !== 8'h0E) $display("FAIL inv_addr_hdr got %h exp 0e", dout); else pass_count++;
      drive(S_IDLE, 1'b0, 8'h00, 1'b0); tick();
      $display("test_invalid_addr done");
   endtask

   initial begin
      test_reset();
      test_packet(8'h0D, 1'b0, "good");
      test_packet(8'hFF, 1'b1, "corrupt");
      test_fifo_full_mid();
      test_full_at_end();
      test_invalid_addr();
      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router.
- Sits between the packet source and the three output FIFOs.
- Driven by the router FSM's state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Latches the header and holds the byte that arrives while the FIFO is full; drives the FIFO write data. Also computes running XOR parity, captures the packet parity byte and flags mismatch, and generates parity_done / low_pkt_valid back to the FSM.

Parameters:
- DATA_WIDTH, 8, byte width of data_in/dout; header bits [1:0] carry the destination address.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  source asserts for header and payload; deasserted with the parity byte
- data_in  in  DATA_WIDTH  packet byte from source
- fifo_full  in  1  full flag of the currently addressed FIFO
- detect_add  in  1  FSM in DECODE_ADDRESS
- lfd_state  in  1  FSM in LOAD_FIRST_DATA
- ld_state  in  1  FSM in LOAD_DATA
- laf_state  in  1  FSM in LOAD_AFTER_FULL
- full_state  in  1  FSM in FIFO_FULL_STATE
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR
- dout  out  DATA_WIDTH  byte to FIFO write port (qualified by the FSM's write_en_reg)
- parity_done  out  1  packet parity byte captured
- low_pkt_valid  out  1  pkt_valid fell while in LOAD_DATA
- err  out  1  parity mismatch for the last packet

Behaviour:
- Reset: all registers update on posedge clk only. reset=1 clears dout, parity_done, low_pkt_valid, err, header, hold_byte, int_parity and pkt_parity to 0. Reset overrides every other condition, including mid-packet.
- Header capture: when detect_add & pkt_valid & data_in[1:0]!=2'b11, header <= data_in. Address 2'b11 is invalid and header keeps its old value.
- dout priority (first match wins):
  - lfd_state: dout <= header.
  - ld_state & ~fifo_full: dout <= data_in.
  - laf_state: dout <= hold_byte.
  - otherwise dout holds.
- hold_byte: ld_state & fifo_full: hold_byte <= data_in. This saves the byte present in the cycle the FIFO filled. Otherwise it holds.
- int_parity:
  - detect_add: 0.
  - lfd_state: int_parity ^= header.
  - ld_state & pkt_valid & ~full_state: int_parity ^= data_in.
  - Otherwise hold. The parity byte itself is never folded in.
- pkt_parity:
  - detect_add: 0.
  - (ld_state & ~fifo_full & ~pkt_valid) | (laf_state & low_pkt_valid & ~parity_done): pkt_parity <= data_in.
- parity_done:
  - detect_add: 0.
  - Either pkt_parity capture condition: 1.
  - Otherwise hold. It is sticky until the next DECODE_ADDRESS.
- low_pkt_valid:
  - rst_int_reg: 0.
  - ld_state & ~pkt_valid: 1.
  - Otherwise hold.
- err:
  - detect_add: 0.
  - parity_done & ~err: err <= (int_parity != pkt_parity). Evaluated the cycle after parity_done rises, so err is valid in CHECK_PARITY_ERROR.
  - Otherwise hold.
- Latency:
  - Header to dout: 1 cycle after the lfd_state edge.
  - Payload: data_in to dout in 1 cycle.
  - Parity byte to err: 2 cycles.
- Simultaneous events: ld_state & fifo_full & ~pkt_valid stores hold_byte only; parity is captured later via the laf_state path. Strobes are one-hot by construction and are not checked.
- Widths: all parity is a bitwise XOR of DATA_WIDTH bits; no carries.

Decomposition:
- Shared package router_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH=2
  - ADDR_INVALID=2'b11
  - FSM state encoding constants, shared with the FSM for assertions
- Optional sub-module router_parity_chk contains int_parity, pkt_parity, parity_done and err, with clear, accumulate-enable and capture-enable inputs. The dout, header and hold logic stays in the top module.

Test Plan:
1. Reset: assert reset mid-packet with dout=8'hA5 -> next cycle dout, err, parity_done and low_pkt_valid are all 0.
2. Good packet:
   - Stimulus: header 8'h0D (addr 1, len 3), payload 8'h11, 8'h22, 8'h33, parity 8'h0D^8'h11^8'h22^8'h33=8'h0D. FSM strobes sequenced; fifo_full=0.
   - Response: dout shows 0D, 11, 22, 33 on consecutive cycles. parity_done=1 the cycle after the parity byte. err=0.
3. Corrupt parity: same packet with parity byte 8'hFF -> err=1 one cycle after parity_done; err clears on the next detect_add.
4. FIFO full mid-payload:
   - Stimulus: fifo_full rises while ld_state and data_in=8'h44.
   - Response: hold_byte=44 and dout unchanged. In laf_state dout=44. int_parity includes 44 exactly once.
5. Full at end of packet:
   - Stimulus: pkt_valid falls during full_state, then laf_state with low_pkt_valid=1.
   - Response: pkt_parity captured from data_in and parity_done=1. A second laf_state cycle does not re-capture.
6. Invalid address: detect_add & pkt_valid with data_in=8'h07 -> header unchanged.
